adder_axi_master: RTL
=====================

Name: adder_axi_master

Overview:
- AXI-lite master that drives the memory-mapped adder slave directly downstream of it.
- Takes a local command (two operands plus a start pulse) and runs four transactions in order: write operand A, write operand B, read sum, read overflow.
- Returns sum and overflow to local logic with a done pulse.
- Detects unresponsive slaves with a per-phase timeout.

Parameters:
- DATA_WIDTH, 32, data bus and operand width.
- ADDR_WIDTH, 8, AXI address width.
- ADDR_A, 0, register address for operand A.
- ADDR_B, 4, register address for operand B.
- ADDR_SUM, 8, register address for the sum.
- ADDR_OVF, 12, register address for the overflow flag.
- TIMEOUT_CYCLES, 16, maximum number of cycles a phase may wait for completion.

Ports:
- m1_axi_aclk  in  1  clock.
- m1_axi_aresetn  in  1  synchronous active-low reset.
- start  in  1  command strobe.
- op_a  in  DATA_WIDTH  operand A.
- op_b  in  DATA_WIDTH  operand B.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle completion pulse.
- sum_out  out  DATA_WIDTH  captured sum.
- ovf_out  out  1  captured overflow flag.
- error  out  1  set when a command aborted or received a bad response.
- m1_axi_awaddr  out  ADDR_WIDTH.
- m1_axi_awvalid  out  1.
- m1_axi_awready  in  1.
- m1_axi_wdata  out  DATA_WIDTH.
- m1_axi_wstrb  out  DATA_WIDTH/8+1  matches the slave's strobe port width.
- m1_axi_wvalid  out  1.
- m1_axi_wready  in  1.
- m1_axi_bresp  in  1  1 = accepted.
- m1_axi_bvalid  in  1.
- m1_axi_bready  out  1.
- m1_axi_araddr  out  ADDR_WIDTH.
- m1_axi_arvalid  out  1.
- m1_axi_arready  in  1  not used; address acceptance is implied by the R handshake.
- m1_axi_rdata  in  DATA_WIDTH.
- m1_axi_rresp  in  1  1 = OK.
- m1_axi_rvalid  in  1.
- m1_axi_rready  out  1.

Behaviour:
- One clock domain. Reset is synchronous and active-low (m1_axi_aresetn sampled on the m1_axi_aclk rising edge).
- Reset values:
  - state = IDLE.
  - All valid and ready outputs 0.
  - busy, done, error, ovf_out = 0; sum_out = 0.
  - awaddr, araddr, wdata = 0.
- wstrb is constant: low DATA_WIDTH/8 bits all 1, top bit 0.
- State sequence: IDLE -> WR_A -> TURN -> WR_B -> TURN -> RD_SUM -> TURN -> RD_OVF -> DONE -> IDLE.
  - A 2-bit phase register selects the successor state on leaving TURN.
- IDLE:
  - start=1 latches op_a and op_b, clears error, sets busy, and moves to WR_A.
  - start while busy is ignored.
- WR_x (x = A or B):
  - awaddr = ADDR_x, wdata = latched operand.
  - awvalid and wvalid are asserted together on state entry; bready is held at 1 for the whole state.
  - awvalid drops on the edge after awready=1 is seen; wvalid drops on the edge after wready=1 is seen. Each is tracked independently.
  - The phase completes on the cycle where both AW and W have been accepted and bvalid&bready=1. bvalid may coincide with awready/wready.
  - bresp=0 at completion sets error; the sequence still continues.
- RD_x (x = SUM or OVF):
  - araddr = ADDR_x; arvalid and rready are both held at 1.
  - Completes on rvalid=1. RD_SUM captures sum_out <= rdata; RD_OVF captures ovf_out <= rdata[0].
  - rresp=0 sets error; the data is still captured.
- TURN: exactly one cycle with all valid and ready outputs at 0. This prevents the slave from re-accepting a held request.
- DONE: done=1 for one cycle, busy drops in the same cycle, next state IDLE.
- Timeout:
  - The phase counter clears on entry to each WR/RD state and increments every cycle the phase has not completed.
  - When it reaches TIMEOUT_CYCLES: all valids and readies drop next edge, error=1, go directly to DONE.
  - Remaining phases are skipped; sum_out and ovf_out keep their previous values.
- Latency with a slave completing each phase in its first cycle: start at edge 0, WR_A in cycle 1, done=1 in cycle 8.
- Reset mid-command: next edge returns to reset values, and no done pulse is produced.
- Simultaneous events: handshake completion and timeout in the same cycle counts as completion.

Test Plan:
- op_a=5, op_b=7, zero-wait slave model -> writes 5 to addr 0, then 7 to addr 4; reads 8 then 12; sum_out=12, ovf_out=0, error=0, done in cycle 8.
- op_a=0xFFFFFFFF, op_b=2, model returns 1 at addr 12 -> sum_out=1, ovf_out=1, error=0.
- Slave delays bvalid by 3 cycles in WR_B -> bready held at 1 throughout, no duplicate AW/W beat, sum_out correct, done in cycle 11.
- Slave never asserts awready (TIMEOUT_CYCLES=16) -> awvalid drops after 16 cycles in WR_A; error=1; done pulse; no AR issued; sum_out unchanged.
- start pulsed again in RD_SUM; reset asserted during RD_OVF -> the second start has no effect; after reset all outputs are 0 and no done pulse is produced; a new start then completes normally.

Source files
------------

// File: rtl/adder_axi_master.sv
// adder_axi_master: AXI-lite master that sequences write A, write B, read sum and read overflow on the adder slave.
// Latency: with a zero-wait slave, start at edge 0 gives WR_A in cycle 1 and done in cycle 8; each phase is bounded by TIMEOUT_CYCLES.
// Backpressure: valids are held until accepted, one idle TURN cycle separates phases, and a stalled phase aborts to DONE with error.
module adder_axi_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int ADDR_A         = 0,
   parameter int ADDR_B         = 4,
   parameter int ADDR_SUM       = 8,
   parameter int ADDR_OVF       = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    m1_axi_aclk,
   input  logic                    m1_axi_aresetn,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   op_a,
   input  logic [DATA_WIDTH-1:0]   op_b,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   sum_out,
   output logic                    ovf_out,
   output logic                    error,
   output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
   output logic                    m1_axi_awvalid,
   input  logic                    m1_axi_awready,
   output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
   output logic [DATA_WIDTH/8:0]   m1_axi_wstrb,
   output logic                    m1_axi_wvalid,
   input  logic                    m1_axi_wready,
   input  logic                    m1_axi_bresp,
   input  logic                    m1_axi_bvalid,
   output logic                    m1_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
   output logic                    m1_axi_arvalid,
   input  logic                    m1_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
   input  logic                    m1_axi_rresp,
   input  logic                    m1_axi_rvalid,
   output logic                    m1_axi_rready
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_A   = 3'd1,
      S_TURN   = 3'd2,
      S_WR_B   = 3'd3,
      S_RD_SUM = 3'd4,
      S_RD_OVF = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   // Phase tags: which transaction was just run, so TURN knows the successor
   localparam logic [1:0] PH_A   = 2'd0;
   localparam logic [1:0] PH_B   = 2'd1;
   localparam logic [1:0] PH_SUM = 2'd2;
   localparam logic [1:0] PH_OVF = 2'd3;

   state_t                r_state;
   logic [1:0]            r_phase;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_op_b;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic                  r_ovf;
   logic [DATA_WIDTH-1:0] r_sum;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;

   logic w_is_wr;
   logic w_is_rd;
   logic w_aw_ok;
   logic w_w_ok;
   logic w_wr_cmpl;
   logic w_rd_cmpl;
   logic w_timeout;
   logic w_unused;

   // Read acceptance is implied by the R handshake, so arready carries no information
   assign w_unused  = m1_axi_arready;

   assign w_is_wr   = (r_state == S_WR_A) || (r_state == S_WR_B);
   assign w_is_rd   = (r_state == S_RD_SUM) || (r_state == S_RD_OVF);
   // An address/data beat counts as accepted if it was taken earlier or is being taken now
   assign w_aw_ok   = r_aw_done || (r_awvalid && m1_axi_awready);
   assign w_w_ok    = r_w_done  || (r_wvalid  && m1_axi_wready);
   assign w_wr_cmpl = w_is_wr && w_aw_ok && w_w_ok && m1_axi_bvalid && r_bready;
   assign w_rd_cmpl = w_is_rd && m1_axi_rvalid && r_rready;
   // Last waiting cycle of a phase; completion in the same cycle still wins
   assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   assign busy           = r_busy;
   assign done           = r_done;
   assign sum_out        = r_sum;
   assign ovf_out        = r_ovf;
   assign error          = r_error;
   assign m1_axi_awaddr  = r_awaddr;
   assign m1_axi_awvalid = r_awvalid;
   assign m1_axi_wdata   = r_wdata;
   assign m1_axi_wstrb   = {1'b0, {(DATA_WIDTH/8){1'b1}}};
   assign m1_axi_wvalid  = r_wvalid;
   assign m1_axi_bready  = r_bready;
   assign m1_axi_araddr  = r_araddr;
   assign m1_axi_arvalid = r_arvalid;
   assign m1_axi_rready  = r_rready;

   // Command sequencer: state, handshake outputs and captured results all registered here
   always_ff @(posedge m1_axi_aclk) begin
      if (!m1_axi_aresetn) begin
         r_state   <= S_IDLE;
         r_phase   <= PH_A;
         r_cnt     <= '0;
         r_op_b    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_ovf     <= 1'b0;
         r_sum     <= '0;
         r_awaddr  <= '0;
         r_araddr  <= '0;
         r_wdata   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op_b    <= op_b;
                  r_error   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_WR_A;
                  r_phase   <= PH_A;
                  r_awaddr  <= ADDR_WIDTH'(ADDR_A);
                  r_wdata   <= op_a;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_bready  <= 1'b1;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_cnt     <= '0;
               end
            end
            S_WR_A, S_WR_B: begin
               if (w_wr_cmpl) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b0;
                  r_bready  <= 1'b0;
                  if (!m1_axi_bresp) r_error <= 1'b1;
                  r_state   <= S_TURN;
               end else if (w_timeout) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b0;
                  r_bready  <= 1'b0;
                  r_error   <= 1'b1;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_awvalid && m1_axi_awready) begin
                     r_awvalid <= 1'b0;
                     r_aw_done <= 1'b1;
                  end
                  if (r_wvalid && m1_axi_wready) begin
                     r_wvalid <= 1'b0;
                     r_w_done <= 1'b1;
                  end
               end
            end
            S_RD_SUM, S_RD_OVF: begin
               if (w_rd_cmpl) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b0;
                  if (!m1_axi_rresp) r_error <= 1'b1;
                  if (r_state == S_RD_SUM) begin
                     r_sum   <= m1_axi_rdata;
                     r_state <= S_TURN;
                  end else begin
                     r_ovf   <= m1_axi_rdata[0];
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end
               end else if (w_timeout) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b0;
                  r_error   <= 1'b1;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_TURN: begin
               r_cnt <= '0;
               case (r_phase)
                  PH_A: begin
                     r_state   <= S_WR_B;
                     r_phase   <= PH_B;
                     r_awaddr  <= ADDR_WIDTH'(ADDR_B);
                     r_wdata   <= r_op_b;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_bready  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                  end
                  PH_B: begin
                     r_state   <= S_RD_SUM;
                     r_phase   <= PH_SUM;
                     r_araddr  <= ADDR_WIDTH'(ADDR_SUM);
                     r_arvalid <= 1'b1;
                     r_rready  <= 1'b1;
                  end
                  PH_SUM: begin
                     r_state   <= S_RD_OVF;
                     r_phase   <= PH_OVF;
                     r_araddr  <= ADDR_WIDTH'(ADDR_OVF);
                     r_arvalid <= 1'b1;
                     r_rready  <= 1'b1;
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
